// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer: drives one shared S-box port through the eight DES
// S-box evaluations of a round. It captures a 48-bit E(R)^K word, issues
// S1..S8 lookups one per cycle and assembles the 32-bit pre-P result.
// LOOKUP_LAT selects the bank latency: 0 = combinational mux, 1 = registered ROM.
module des_sbox_sequencer #(
  parameter int LOOKUP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [47:0] in_data_i,
  input  logic        abort_i,
  output logic [2:0]  sb_sel_o,
  output logic [5:0]  sb_in_o,
  output logic        sb_req_o,
  input  logic [3:0]  sb_out_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] in_reg_q, in_reg_d;
  logic [2:0]  iss_q, iss_d;           // index of the next lookup to issue
  logic [2:0]  cap_q, cap_d;           // index of the next result to capture
  logic        iss_done_q, iss_done_d; // all eight lookups issued, waiting on the last result
  logic        pend_q, pend_d;         // a lookup was issued last cycle (registered bank only)
  logic [31:0] out_data_q, out_data_d;
  logic [2:0]  sel_hold_q, sel_hold_d;
  logic [5:0]  sbin_hold_q, sbin_hold_d;

  logic        sb_req_s;
  logic        cap_fire_s;
  logic [47:0] shifted_s;
  logic [5:0]  lookup_in_s;
  logic [4:0]  nib_sh_s;

  // Lookups are issued while running until the eighth one has gone out.
  assign sb_req_s    = (state_q == RUN) && !iss_done_q;
  // Bring the 6-bit group for the current S-box to the top of the word.
  assign shifted_s   = in_reg_q << (6'(iss_q) * 6'd6);
  assign lookup_in_s = shifted_s[47:42];
  // A combinational bank answers in the issue cycle, a ROM one cycle later.
  assign cap_fire_s  = (state_q == RUN) && !abort_i &&
                       ((LOOKUP_LAT == 0) ? sb_req_s : pend_q);
  assign nib_sh_s    = {cap_q, 2'b00};

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sb_req_o    = sb_req_s;
  // Between lookups the port shows the last issued select and index.
  assign sb_sel_o    = sb_req_s ? iss_q : sel_hold_q;
  assign sb_in_o     = sb_req_s ? lookup_in_s : sbin_hold_q;
  assign out_data_o  = out_data_q;

  // Next-state logic for the sequencer FSM, counters and result register.
  always_comb begin
    state_d     = state_q;
    in_reg_d    = in_reg_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    iss_done_d  = iss_done_q;
    pend_d      = 1'b0;
    out_data_d  = out_data_q;
    sel_hold_d  = sel_hold_q;
    sbin_hold_d = sbin_hold_q;

    if (sb_req_s) begin
      sel_hold_d  = iss_q;
      sbin_hold_d = lookup_in_s;
    end else begin
      sel_hold_d  = sel_hold_q;
      sbin_hold_d = sbin_hold_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid_i && !abort_i) begin
          in_reg_d   = in_data_i;
          iss_d      = 3'd0;
          cap_d      = 3'd0;
          iss_done_d = 1'b0;
          state_d    = RUN;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          // Drop the partial word; any lookup in flight is forgotten.
          state_d    = IDLE;
          iss_d      = 3'd0;
          cap_d      = 3'd0;
          iss_done_d = 1'b0;
          pend_d     = 1'b0;
        end else begin
          pend_d = sb_req_s;
          if (sb_req_s) begin
            if (iss_q == 3'd7) begin
              iss_done_d = 1'b1;
            end else begin
              iss_d = iss_q + 3'd1;
            end
          end else begin
            iss_d = iss_q;
          end
          if (cap_fire_s) begin
            out_data_d = (out_data_q & ~(32'hF000_0000 >> nib_sh_s)) |
                         ({sb_out_i, 28'd0} >> nib_sh_s);
            if (cap_q == 3'd7) begin
              state_d    = DONE;
              cap_d      = 3'd0;
              iss_d      = 3'd0;
              iss_done_d = 1'b0;
            end else begin
              cap_d = cap_q + 3'd1;
            end
          end else begin
            cap_d = cap_q;
          end
        end
      end
      DONE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_reg_q    <= 48'd0;
      iss_q       <= 3'd0;
      cap_q       <= 3'd0;
      iss_done_q  <= 1'b0;
      pend_q      <= 1'b0;
      out_data_q  <= 32'd0;
      sel_hold_q  <= 3'd0;
      sbin_hold_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      in_reg_q    <= in_reg_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      iss_done_q  <= iss_done_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      sel_hold_q  <= sel_hold_d;
      sbin_hold_q <= sbin_hold_d;
    end
  end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Bench for des_sbox_sequencer: one instance per bank latency, each with its
// own S-box bank model, checked every cycle against a transaction-level model
// that knows only the word-level DES S-box function and the cycle timing.
module tb_des_sbox_sequencer;

  // DES S-boxes, one 64-bit entry per row (16 nibbles, column 0 first), S1 row0 first.
  localparam logic [63:0] SB_TAB [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [5:0] x);
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] r;
    row = {x[5], x[0]};
    col = x[4:1];
    r   = SB_TAB[{sel, row}];
    r   = r >> (4 * (15 - int'(col)));
    return r[3:0];
  endfunction

  function automatic logic [31:0] des_sbox_word(input logic [47:0] w);
    logic [31:0] r;
    logic [47:0] t;
    r = 32'd0;
    for (int k = 0; k < 8; k++) begin
      t = w << (6 * k);
      r = {r[27:0], sbox_lookup(3'(k), t[47:42])};
    end
    return r;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid, in_ready, abort, sb_req, out_valid, out_ready;
  logic [47:0] in_data [2];
  logic [2:0]  sb_sel [2];
  logic [5:0]  sb_in [2];
  logic [31:0] out_data [2];
  logic [3:0]  sb_out0, sb_out1;

  int n_cmp = 0;
  int n_fail = 0;

  // model state per instance
  bit          pend [2];
  int          wt [2];
  logic [47:0] wrd [2];
  logic [31:0] expv [2];
  int          xfer [2];

  always #5 clk = ~clk;

  des_sbox_sequencer #(.LOOKUP_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .abort_i(abort[0]), .sb_sel_o(sb_sel[0]), .sb_in_o(sb_in[0]), .sb_req_o(sb_req[0]),
    .sb_out_i(sb_out0), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(out_data[0])
  );

  des_sbox_sequencer #(.LOOKUP_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .abort_i(abort[1]), .sb_sel_o(sb_sel[1]), .sb_in_o(sb_in[1]), .sb_req_o(sb_req[1]),
    .sb_out_i(sb_out1), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(out_data[1])
  );

  // combinational S1..S8 mux bank
  always_comb sb_out0 = sbox_lookup(sb_sel[0], sb_in[0]);
  // registered ROM bank
  always @(posedge clk) sb_out1 <= sbox_lookup(sb_sel[1], sb_in[1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison and model update for one instance, at the negedge.
  task automatic model_cmp(input int d);
    logic [47:0] t;
    bit ev, er;
    if (pend[d]) wt[d]++;
    ev = pend[d] && (wt[d] >= 9 + d);
    er = pend[d] && (wt[d] >= 1) && (wt[d] <= 8);
    chk($sformatf("lat%0d in_ready", d), 64'(in_ready[d]), 64'(!pend[d]));
    chk($sformatf("lat%0d out_valid", d), 64'(out_valid[d]), 64'(ev));
    chk($sformatf("lat%0d sb_req", d), 64'(sb_req[d]), 64'(er));
    if (er) begin
      t = wrd[d] << (6 * (wt[d] - 1));
      chk($sformatf("lat%0d sb_sel", d), 64'(sb_sel[d]), 64'(wt[d] - 1));
      chk($sformatf("lat%0d sb_in", d), 64'(sb_in[d]), 64'(t[47:42]));
    end
    if (ev) chk($sformatf("lat%0d out_data", d), 64'(out_data[d]), 64'(expv[d]));
    if (pend[d] && abort[d]) begin
      pend[d] = 1'b0;
    end else if (ev && out_ready[d]) begin
      pend[d] = 1'b0;
      xfer[d]++;
    end else if (!pend[d] && in_valid[d] && !abort[d]) begin
      pend[d] = 1'b1;
      wrd[d]  = in_data[d];
      expv[d] = des_sbox_word(in_data[d]);
      wt[d]   = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cmp(0);
    model_cmp(1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input int d, input logic [47:0] data, input logic [31:0] lit, input int hold);
    int cnt;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    out_ready[d] = 1'b0;
    step();
    in_valid[d] = 1'b0;
    cnt = 0;
    while (!out_valid[d] && cnt < 40) begin
      step();
      cnt++;
    end
    chk($sformatf("lat%0d latency", d), 64'(cnt), 64'(8 + d));
    chk($sformatf("lat%0d word %0h", d, data), 64'(out_data[d]), 64'(lit));
    repeat (hold) step();
    chk($sformatf("lat%0d held in_ready", d), 64'(in_ready[d]), 64'd0);
    chk($sformatf("lat%0d held out_valid", d), 64'(out_valid[d]), 64'd1);
    chk($sformatf("lat%0d held out_data", d), 64'(out_data[d]), 64'(lit));
    out_ready[d] = 1'b1;
    step();
    chk($sformatf("lat%0d post in_ready", d), 64'(in_ready[d]), 64'd1);
    chk($sformatf("lat%0d post out_valid", d), 64'(out_valid[d]), 64'd0);
    chk($sformatf("lat%0d post out_data", d), 64'(out_data[d]), 64'(lit));
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s lat%0d in_ready", tag, d), 64'(in_ready[d]), 64'd1);
      chk($sformatf("%s lat%0d out_valid", tag, d), 64'(out_valid[d]), 64'd0);
      chk($sformatf("%s lat%0d sb_req", tag, d), 64'(sb_req[d]), 64'd0);
      chk($sformatf("%s lat%0d sb_sel", tag, d), 64'(sb_sel[d]), 64'd0);
      chk($sformatf("%s lat%0d sb_in", tag, d), 64'(sb_in[d]), 64'd0);
      chk($sformatf("%s lat%0d out_data", tag, d), 64'(out_data[d]), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    in_valid  = 2'b00;
    abort     = 2'b00;
    out_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      in_data[d] = 48'd0;
      pend[d] = 1'b0;
      wt[d]   = 0;
      wrd[d]  = 48'd0;
      expv[d] = 32'd0;
      xfer[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // pin the model with hand-computed words
    chk("model zero", 64'(des_sbox_word(48'h0)), 64'h0000_0000_EFA7_2C4D);
    chk("model ones", 64'(des_sbox_word(48'hFFFF_FFFF_FFFF)), 64'h0000_0000_D9CE_3DCB);
    chk("model 041", 64'(des_sbox_word(48'h0410_4104_1041)), 64'h0000_0000_03DD_EAD1);

    // known words through both bank latencies
    for (int d = 0; d < 2; d++) begin
      run_word(d, 48'h0, 32'hEFA72C4D, 0);
      run_word(d, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 0);
    end

    // backpressure: 20 cycles of out_ready low in DONE
    run_word(0, 48'h0410_4104_1041, 32'h03DDEAD1, 20);
    run_word(1, 48'h0410_4104_1041, 32'h03DDEAD1, 20);

    // abort during issue 4 with the registered bank
    in_valid[1] = 1'b1;
    in_data[1]  = 48'hFFFF_FFFF_FFFF;
    step();
    in_valid[1] = 1'b0;
    repeat (4) step();
    chk("abort issue4 sb_req", 64'(sb_req[1]), 64'd1);
    chk("abort issue4 sb_sel", 64'(sb_sel[1]), 64'd4);
    abort[1] = 1'b1;
    step();
    abort[1] = 1'b0;
    chk("abort in_ready", 64'(in_ready[1]), 64'd1);
    chk("abort out_valid", 64'(out_valid[1]), 64'd0);
    chk("abort sb_req", 64'(sb_req[1]), 64'd0);
    repeat (12) step();
    chk("abort no out_valid", 64'(out_valid[1]), 64'd0);
    run_word(1, 48'h0, 32'hEFA72C4D, 0);

    // abort in DONE beats out_ready; abort in IDLE beats in_valid
    in_valid[0] = 1'b1;
    in_data[0]  = 48'h0;
    out_ready[0] = 1'b0;
    step();
    in_valid[0] = 1'b0;
    repeat (8) step();
    chk("done abort pre out_valid", 64'(out_valid[0]), 64'd1);
    abort[0] = 1'b1;
    out_ready[0] = 1'b1;
    step();
    chk("done abort in_ready", 64'(in_ready[0]), 64'd1);
    chk("done abort out_valid", 64'(out_valid[0]), 64'd0);
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    abort[0] = 1'b0;
    chk("idle abort no capture", 64'(in_ready[0]), 64'd1);
    chk("idle abort sb_req", 64'(sb_req[0]), 64'd0);
    step();

    // asynchronous reset in the middle of a run
    in_valid = 2'b11;
    in_data[0] = 48'hFFFF_FFFF_FFFF;
    in_data[1] = 48'h0410_4104_1041;
    step();
    in_valid = 2'b00;
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun reset");
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    #1 rst_n = 1'b1;
    step();

    // random stream on both instances
    xfer[0] = 0;
    xfer[1] = 0;
    cyc = 0;
    while ((xfer[0] + xfer[1] < 1000) && cyc < 40000) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(3) != 0);
        in_data[d]   = {16'($urandom), $urandom};
        out_ready[d] = ($urandom_range(3) != 0);
        abort[d]     = ($urandom_range(63) == 0);
      end
      step();
      cyc++;
    end
    chk("stream words done", 64'(xfer[0] + xfer[1] >= 1000), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
